bin2bcd_seq: RTL and testbench
==============================

# bin2bcd_seq

Parametrised, handshaked successor to the clock's fixed 8-bit binary-to-BCD converter. It converts a BIN_WIDTH-bit unsigned value to BCD_DIGITS packed BCD digits using sequential double-dabble (shift-add-3), at one bit per clock. It adds valid/ready flow control on both sides and a leading-zero blanking mask for the seven-segment display drivers. It sits between the time/counter logic and the digit multiplexer.

## Interface
- BIN_WIDTH, 8, width of the binary input; must be ≥ 1.
- BCD_DIGITS, 3, number of output digits.
  - Must satisfy 10^BCD_DIGITS > 2^BIN_WIDTH − 1.
  - Violation is an elaboration-time error.

- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_bin  in  BIN_WIDTH  unsigned binary value; sampled only on accept.
- i_valid  in  1  input value present.
- o_ready  out  1  converter can accept; high only in IDLE.
- o_bcd  out  4*BCD_DIGITS  packed BCD result; digit 0 (units) in bits [3:0].
- o_blank  out  BCD_DIGITS  bit k = 1 means digit k is a leading zero; bit 0 is always 0.
- o_valid  out  1  o_bcd/o_blank hold a fresh result.
- i_ready  in  1  downstream takes the result.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - o_ready=1, o_valid=0.
  - On i_valid=1: load the shift register with i_bin, clear the BCD accumulator and bit counter, go to SHIFT.
  - On i_valid=0: stay in IDLE.
- SHIFT, once per cycle:
  - Every accumulator digit ≥ 5 gets +3.
  - Then shift {accumulator, shift register} left by one, MSB of the binary first.
  - Increment the counter.
  - After the BIN_WIDTH-th shift, register the accumulator into o_bcd, compute o_blank, go to DONE.
- DONE:
  - o_valid=1; o_bcd/o_blank held stable.
  - On i_ready=1: go to IDLE.
  - On i_ready=0: hold indefinitely.
- Inputs are ignored outside an accept cycle: i_bin changes and i_valid pulses while busy have no effect.
- o_bcd/o_blank retain the last result through IDLE and SHIFT, and change only on entry to DONE.
- Blanking: scan from the most significant digit. o_blank[k]=1 iff digit k and all higher digits are 0, with k ≥ 1.
- Digit arithmetic is 4-bit. After the add-3 step no digit exceeds 4'b1100, so the shift never overflows a digit.
- Counter width: $clog2(BIN_WIDTH+1).

## Timing
- Reset, asynchronous, immediate, including mid-conversion:
  - State = IDLE.
  - o_bcd=0, o_blank = all ones except bit 0, o_valid=0.
  - o_ready=1 once rst_n is high.
  - Any partial conversion is discarded.
- Latency: accept edge at cycle N, then o_valid=1 from cycle N+BIN_WIDTH+1. There are BIN_WIDTH SHIFT cycles.
- Throughput: one conversion per BIN_WIDTH+2 cycles with i_ready held high. DONE→IDLE costs one cycle; there is no accept in DONE.
- o_ready and o_valid are registered state decodes, never simultaneously high, with no combinational path from i_valid/i_ready.
- Simultaneous reset release and i_valid=1: the first accept is on the first rising edge with rst_n high.

## Structure
- Shared package clock_pkg:
  - BCD_DIGIT_W = 4.
  - Add-3 threshold 4'd5.
  - State enum typedef (IDLE/SHIFT/DONE).
  - Helper function for the minimum digit count, used by the elaboration check.
- One sub-module, bcd_digit_adj: combinational per-digit add-3. It is instantiated BCD_DIGITS times via generate.
- Expected size is about 150–250 lines including the generate and the blanking scan.

## Test plan
- Reset then i_bin=8'd0, i_valid pulse:
  - o_valid rises 9 cycles after accept.
  - o_bcd=12'h000, o_blank=3'b110.
- i_bin=8'd255 → o_bcd=12'h255, o_blank=3'b000. i_bin=8'd10 → 12'h010, o_blank=3'b100. i_bin=8'd4 → 12'h004, o_blank=3'b110.
- Backpressure:
  - Convert 8'd128 with i_ready=0 for 20 cycles: o_valid stays 1, o_bcd=12'h128 stable, o_ready=0.
  - i_ready=1 for one cycle: IDLE next cycle.
- Busy: hold i_valid=1 with i_bin changing 4→64 mid-conversion.
  - First result 12'h004.
  - 8'd64 accepted only after returning to IDLE, giving 12'h064.
- Reset mid-SHIFT (cycle 4 of 8): outputs go to reset values immediately, with no o_valid. A new conversion afterwards is correct.
- Parametrised instance with BIN_WIDTH=17, BCD_DIGITS=6, i_bin=131071 → o_bcd=24'h131071 at latency 18.
  - Same instance, i_bin=7 → 24'h000007, o_blank=6'b111110.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared definitions for the binary-to-BCD converter: digit width, add-3
// threshold, FSM state encoding and the minimum-digit-count helper.
package clock_pkg;

    localparam int BCD_DIGIT_W = 4;
    localparam logic [BCD_DIGIT_W-1:0] ADD3_THRESHOLD = 4'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_e;

    // Decimal digits of 2^w - 1 equal those of 2^w (never a power of ten),
    // i.e. floor(w*log10(2)) + 1; log10(2) is approximated by 30103/100000.
    function automatic int min_bcd_digits(input int bin_width);
        longint scaled;
        scaled = (longint'(bin_width) * 64'sd30103) / 64'sd100000;
        return int'(scaled) + 1;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Valid/ready bundle between the binary source, the BCD converter and the
// digit multiplexer; slave is the converter side, master is the source/sink.
interface bin2bcd_seq_if #(
    parameter int BIN_WIDTH  = 8,
    parameter int BCD_DIGITS = 3
);
    logic [BIN_WIDTH-1:0]                        i_bin;
    logic                                        i_valid;
    logic                                        o_ready;
    logic [clock_pkg::BCD_DIGIT_W*BCD_DIGITS-1:0] o_bcd;
    logic [BCD_DIGITS-1:0]                       o_blank;
    logic                                        o_valid;
    logic                                        i_ready;

    modport slave (
        input  i_bin, i_valid, i_ready,
        output o_ready, o_bcd, o_blank, o_valid
    );

    modport master (
        output i_bin, i_valid, i_ready,
        input  o_ready, o_bcd, o_blank, o_valid
    );
endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or
// more so that the following left shift carries correctly into the next digit.
module bcd_digit_adj
    import clock_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_i,
    output logic [BCD_DIGIT_W-1:0] digit_o
);

    assign digit_o = (digit_i >= ADD3_THRESHOLD) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock, with
// valid/ready handshakes on both sides and a leading-zero blanking mask.
module bin2bcd_seq
    import clock_pkg::*;
#(
    parameter int BIN_WIDTH  = 8,
    parameter int BCD_DIGITS = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    bin2bcd_seq_if.slave  bus
);

    localparam int ACC_W = BCD_DIGIT_W * BCD_DIGITS;
    localparam int CNT_W = $clog2(BIN_WIDTH + 1);
    localparam logic [BCD_DIGITS-1:0] BLANK_RST = ~BCD_DIGITS'(1);

    if (BIN_WIDTH < 1) begin : g_bad_width
        $error("bin2bcd_seq: BIN_WIDTH must be at least 1");
    end
    if (BCD_DIGITS < min_bcd_digits(BIN_WIDTH)) begin : g_bad_digits
        $error("bin2bcd_seq: BCD_DIGITS too small for BIN_WIDTH");
    end

    conv_state_e            state_q, state_d;
    logic [BIN_WIDTH-1:0]   sr_q, sr_d, sr_shift;
    logic [ACC_W-1:0]       acc_q, acc_d, acc_adj, acc_shift;
    logic [ACC_W-1:0]       bcd_q, bcd_d;
    logic [BCD_DIGITS-1:0]  blank_q, blank_d, blank_scan;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_i (acc_q  [gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digit_o (acc_adj[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    always_comb begin
        {acc_shift, sr_shift} = {acc_adj, sr_q} << 1;
    end

    // Leading-zero mask of the value about to be published; digit 0 always shows.
    always_comb begin
        logic zero_run;
        blank_scan = '0;
        zero_run   = 1'b1;
        for (int k = BCD_DIGITS - 1; k >= 1; k--) begin
            zero_run      = zero_run && (acc_shift[k*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
            blank_scan[k] = zero_run;
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        blank_d = blank_q;
        case (state_q)
            IDLE: begin
                if (bus.i_valid) begin
                    sr_d    = bus.i_bin;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sr_d  = sr_shift;
                acc_d = acc_shift;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(BIN_WIDTH - 1)) begin
                    bcd_d   = acc_shift;
                    blank_d = blank_scan;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.i_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            blank_q <= BLANK_RST;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            blank_q <= blank_d;
        end
    end

    assign bus.o_ready = (state_q == IDLE);
    assign bus.o_valid = (state_q == DONE);
    assign bus.o_bcd   = bcd_q;
    assign bus.o_blank = blank_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed-vector bench for bin2bcd_seq: default 8-bit/3-digit instance plus a
// 17-bit/6-digit instance sharing clock and reset.
module tb_bin2bcd_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    bin2bcd_seq_if #(.BIN_WIDTH(8),  .BCD_DIGITS(3)) bus8  ();
    bin2bcd_seq_if #(.BIN_WIDTH(17), .BCD_DIGITS(6)) bus17 ();

    bin2bcd_seq #(.BIN_WIDTH(8), .BCD_DIGITS(3)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    bin2bcd_seq #(.BIN_WIDTH(17), .BCD_DIGITS(6)) u_dut17 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus17)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic cur_valid(input int sel);
        return (sel == 0) ? bus8.o_valid : bus17.o_valid;
    endfunction

    function automatic logic cur_ready(input int sel);
        return (sel == 0) ? bus8.o_ready : bus17.o_ready;
    endfunction

    function automatic logic [23:0] cur_bcd(input int sel);
        return (sel == 0) ? {12'h0, bus8.o_bcd} : bus17.o_bcd;
    endfunction

    function automatic logic [5:0] cur_blank(input int sel);
        return (sel == 0) ? {3'b0, bus8.o_blank} : bus17.o_blank;
    endfunction

    task automatic set_in(input int sel, input logic valid, input logic [23:0] bin, input logic rdy);
        if (sel == 0) begin
            bus8.i_valid = valid;
            bus8.i_bin   = bin[7:0];
            bus8.i_ready = rdy;
        end else begin
            bus17.i_valid = valid;
            bus17.i_bin   = bin[16:0];
            bus17.i_ready = rdy;
        end
    endtask

    // One full transaction: accept, wait bounded for o_valid, check, handshake out.
    task automatic convert(input int sel, input logic [23:0] v, input logic [23:0] exp_bcd,
                           input logic [5:0] exp_blank, input int exp_lat, input string tag);
        int lat;
        @(negedge clk);
        check_val({tag, "_ready_idle"}, 32'(cur_ready(sel)), 32'd1);
        set_in(sel, 1'b1, v, 1'b0);
        lat = 0;
        do begin
            @(negedge clk);
            set_in(sel, 1'b0, v, 1'b0);
            lat++;
        end while (!cur_valid(sel) && lat < 40);
        check_val({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check_val({tag, "_bcd"},     32'(cur_bcd(sel)), 32'(exp_bcd));
        check_val({tag, "_blank"},   32'(cur_blank(sel)), 32'(exp_blank));
        check_val({tag, "_ready_done"}, 32'(cur_ready(sel)), 32'd0);
        set_in(sel, 1'b0, v, 1'b1);
        @(negedge clk);
        set_in(sel, 1'b0, v, 1'b0);
        check_val({tag, "_valid_after"}, 32'(cur_valid(sel)), 32'd0);
        check_val({tag, "_ready_after"}, 32'(cur_ready(sel)), 32'd1);
        $display("txn %s: bin=%0d bcd=%0h blank=%b latency=%0d", tag, v, cur_bcd(sel), cur_blank(sel), lat);
    endtask

    initial begin
        int lat;
        set_in(0, 1'b0, 24'd0, 1'b0);
        set_in(1, 1'b0, 24'd0, 1'b0);

        repeat (3) @(negedge clk);
        check_val("rst_bcd",   32'(bus8.o_bcd),   32'h000);
        check_val("rst_blank", 32'(bus8.o_blank), 32'b110);
        check_val("rst_valid", 32'(bus8.o_valid), 32'd0);
        check_val("rst_blank17", 32'(bus17.o_blank), 32'b111110);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("rst_ready", 32'(bus8.o_ready), 32'd1);

        convert(0, 24'd0,   24'h000, 6'b110, 9, "zero");
        convert(0, 24'd255, 24'h255, 6'b000, 9, "d255");
        convert(0, 24'd10,  24'h010, 6'b100, 9, "d10");
        convert(0, 24'd4,   24'h004, 6'b110, 9, "d4");

        // Backpressure: result must hold while i_ready stays low.
        @(negedge clk);
        set_in(0, 1'b1, 24'd128, 1'b0);
        lat = 0;
        do begin
            @(negedge clk);
            set_in(0, 1'b0, 24'd128, 1'b0);
            lat++;
        end while (!bus8.o_valid && lat < 40);
        check_val("bp_latency", 32'(lat), 32'd9);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_val("bp_valid", 32'(bus8.o_valid), 32'd1);
            check_val("bp_bcd",   32'(bus8.o_bcd),   32'h128);
            check_val("bp_ready", 32'(bus8.o_ready), 32'd0);
        end
        bus8.i_ready = 1'b1;
        @(negedge clk);
        bus8.i_ready = 1'b0;
        check_val("bp_ready_idle", 32'(bus8.o_ready), 32'd1);
        check_val("bp_valid_idle", 32'(bus8.o_valid), 32'd0);
        check_val("bp_bcd_kept",   32'(bus8.o_bcd),   32'h128);
        $display("txn backpressure: bin=128 bcd=%0h held 20 cycles", bus8.o_bcd);

        // Busy: i_valid held high, i_bin changes while converting.
        @(negedge clk);
        set_in(0, 1'b1, 24'd4, 1'b0);
        repeat (3) @(negedge clk);
        bus8.i_bin = 8'd64;
        lat = 3;
        while (!bus8.o_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check_val("busy_latency", 32'(lat), 32'd9);
        check_val("busy_first",   32'(bus8.o_bcd), 32'h004);
        check_val("busy_blank1",  32'(bus8.o_blank), 32'b110);
        bus8.i_ready = 1'b1;
        @(negedge clk);
        bus8.i_ready = 1'b0;
        check_val("busy_idle_ready", 32'(bus8.o_ready), 32'd1);
        @(negedge clk);
        bus8.i_valid = 1'b0;
        check_val("busy_accept", 32'(bus8.o_ready), 32'd0);
        lat = 1;
        while (!bus8.o_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check_val("busy_latency2", 32'(lat), 32'd9);
        check_val("busy_second",   32'(bus8.o_bcd), 32'h064);
        check_val("busy_blank2",   32'(bus8.o_blank), 32'b100);
        bus8.i_ready = 1'b1;
        @(negedge clk);
        bus8.i_ready = 1'b0;
        $display("txn busy: results 004 then %0h", bus8.o_bcd);

        // Reset during the fourth SHIFT cycle.
        @(negedge clk);
        set_in(0, 1'b1, 24'd200, 1'b0);
        @(negedge clk);
        bus8.i_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("mid_rst_bcd",   32'(bus8.o_bcd),   32'h000);
        check_val("mid_rst_blank", 32'(bus8.o_blank), 32'b110);
        check_val("mid_rst_valid", 32'(bus8.o_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check_val("mid_rst_novalid", 32'(bus8.o_valid), 32'd0);
        end
        check_val("mid_rst_ready", 32'(bus8.o_ready), 32'd1);
        $display("txn reset_mid_shift: outputs cleared, no result produced");
        convert(0, 24'd200, 24'h200, 6'b000, 9, "post_rst");

        convert(1, 24'd131071, 24'h131071, 6'b000000, 18, "w17_max");
        convert(1, 24'd7,      24'h000007, 6'b111110, 18, "w17_7");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
